// File: rtl/dsm_pkg.sv
// Shared definitions for the MASH 1-1-1 recombination path.
// Covers the order encodings and the fractional-code range.
package dsm_pkg;

  localparam int FRAC_W   = 4;
  localparam int FRAC_MIN = -3;
  localparam int FRAC_MAX = 4;

  typedef enum logic [1:0] {
    ORD_INT   = 2'd0,
    ORD_MASH1 = 2'd1,
    ORD_MASH2 = 2'd2,
    ORD_MASH3 = 2'd3
  } order_e;

  typedef logic signed [FRAC_W-1:0] frac_t;

endpackage

// File: rtl/mash_noise_cancel_if.sv
// Modulator-side bundle: carry bits, order and divide value in, divider code out.
interface mash_noise_cancel_if #(
  parameter int DIV_W  = 8,
  parameter int FRAC_W = 4
);
  logic              En;
  logic              C1;
  logic              C2;
  logic              C3;
  logic [1:0]        Order;
  logic [DIV_W-1:0]  N_Int;
  logic [FRAC_W-1:0] Frac_Out;
  logic [DIV_W-1:0]  Div_Ratio;
  logic              Sat;
  logic              Valid;

  modport master (
    output En, C1, C2, C3, Order, N_Int,
    input  Frac_Out, Div_Ratio, Sat, Valid
  );

  modport slave (
    input  En, C1, C2, C3, Order, N_Int,
    output Frac_Out, Div_Ratio, Sat, Valid
  );
endinterface

// File: rtl/dsm_diff.sv
// First-difference stage y = x - x_d1; the delay register only advances on strobes.
module dsm_diff #(
  parameter int W = 5
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic signed [W-1:0] i_x,
  output logic signed [W-1:0] o_y
);

  logic signed [W-1:0] r_x_d1;

  // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_x_d1 <= '0;
    end else if (i_en) begin
      r_x_d1 <= i_x;
    end
  end

  assign o_y = i_x - r_x_d1;

endmodule

// File: rtl/mash_noise_cancel.sv
// MASH 1-1-1 noise-cancellation network: y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3,
// added to the integer divide value and clamped into the divider's range.
module mash_noise_cancel #(
  parameter int DIV_W  = 8,
  parameter int FRAC_W = dsm_pkg::FRAC_W
) (
  input logic                  Clk,
  input logic                  reset,
  mash_noise_cancel_if.slave   bus
);

  import dsm_pkg::*;

  localparam int YW = FRAC_W + 1;
  localparam int SW = DIV_W + 2;
  localparam logic signed [SW-1:0] DIV_MAX = SW'((1 << DIV_W) - 1);

  order_e                 w_order;
  logic signed [YW-1:0]   w_c1;
  logic signed [YW-1:0]   w_c2;
  logic signed [YW-1:0]   w_c3;
  logic signed [YW-1:0]   w_d2;
  logic signed [YW-1:0]   w_e3;
  logic signed [YW-1:0]   w_f3;
  logic signed [YW-1:0]   w_y;
  logic signed [SW-1:0]   w_sum;
  logic [DIV_W-1:0]       w_ratio;
  logic                   w_sat;

  logic [FRAC_W-1:0]      r_frac;
  logic [DIV_W-1:0]       r_div;
  logic                   r_sat;
  logic                   r_valid;
  logic [1:0]             r_fill;

  assign w_order = order_e'(bus.Order);
  assign w_c1    = {{(YW-1){1'b0}}, bus.C1};
  assign w_c2    = {{(YW-1){1'b0}}, bus.C2};
  assign w_c3    = {{(YW-1){1'b0}}, bus.C3};

  // Differentiator history shifts on every strobe whatever the order, so an
  // order change always lands on correctly aligned history.
  dsm_diff #(.W(YW)) u_diff_c2 (
    .Clk (Clk), .reset (reset), .i_en (bus.En), .i_x (w_c2), .o_y (w_d2)
  );

  dsm_diff #(.W(YW)) u_diff_c3a (
    .Clk (Clk), .reset (reset), .i_en (bus.En), .i_x (w_c3), .o_y (w_e3)
  );

  dsm_diff #(.W(YW)) u_diff_c3b (
    .Clk (Clk), .reset (reset), .i_en (bus.En), .i_x (w_e3), .o_y (w_f3)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_y = '0;
    case (w_order)
      ORD_INT:   w_y = '0;
      ORD_MASH1: w_y = w_c1;
      ORD_MASH2: w_y = w_c1 + w_d2;
      ORD_MASH3: w_y = w_c1 + w_d2 + w_f3;
      default:   w_y = '0;
    endcase
  end

  assign w_sum = $signed({2'b00, bus.N_Int}) + {{(SW-YW){w_y[YW-1]}}, w_y};

  always_comb begin
    w_ratio = w_sum[DIV_W-1:0];
    w_sat   = 1'b0;
    if (w_sum < 0) begin
      w_ratio = '0;
      w_sat   = 1'b1;
    end else if (w_sum > DIV_MAX) begin
      w_ratio = '1;
      w_sat   = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_frac  <= '0;
      r_div   <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
      r_fill  <= 2'd0;
    end else if (bus.En) begin
      r_frac  <= w_y[FRAC_W-1:0];
      r_div   <= w_ratio;
      r_sat   <= w_sat;
      r_fill  <= (r_fill == 2'd2) ? 2'd2 : r_fill + 2'd1;
      r_valid <= (r_fill == 2'd2);
    end
  end

  assign bus.Frac_Out  = r_frac;
  assign bus.Div_Ratio = r_div;
  assign bus.Sat       = r_sat;
  assign bus.Valid     = r_valid;

endmodule

// File: tb/tb_mash_noise_cancel.sv
// Directed-vector bench for mash_noise_cancel; expected values are hand-computed.
module tb_mash_noise_cancel;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  mash_noise_cancel_if #(.DIV_W(8), .FRAC_W(4)) bus ();

  mash_noise_cancel #(.DIV_W(8), .FRAC_W(4)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic do_reset();
    @(negedge Clk);
    reset  = 1'b1;
    bus.En = 1'b0;
    @(negedge Clk);
    reset  = 1'b0;
  endtask

  // One strobe: inputs set at the falling edge, outputs settled 1 ns after the rising edge.
  task automatic strobe(input logic c1, input logic c2, input logic c3);
    @(negedge Clk);
    bus.C1 = c1;
    bus.C2 = c2;
    bus.C3 = c3;
    bus.En = 1'b1;
    @(posedge Clk);
    #1;
    bus.En = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      bus.En    = 1'($urandom);
      bus.C1    = 1'($urandom);
      bus.C2    = 1'($urandom);
      bus.C3    = 1'($urandom);
      bus.Order = 2'($urandom);
      bus.N_Int = 8'($urandom);
    end
    #1;
    n_vec++; if (bus.Frac_Out !== 4'd0) begin n_err++; $display("FAIL reset frac: got %0d want 0", $signed(bus.Frac_Out)); end
    n_vec++; if (bus.Div_Ratio !== 8'd0) begin n_err++; $display("FAIL reset div: got %0d want 0", bus.Div_Ratio); end
    n_vec++; if (bus.Sat !== 1'b0) begin n_err++; $display("FAIL reset sat: got %b want 0", bus.Sat); end
    n_vec++; if (bus.Valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b want 0", bus.Valid); end

    @(negedge Clk);
    reset     = 1'b0;
    bus.En    = 1'b0;
    bus.Order = 2'd3;
    bus.N_Int = 8'd128;
    for (int i = 0; i < 10; i++) strobe(1'($urandom), 1'($urandom), 1'($urandom));

    // Mid-run reset asserted away from any rising edge must clear outputs at once.
    @(negedge Clk);
    reset = 1'b1;
    #1;
    n_vec++; if (bus.Frac_Out !== 4'd0) begin n_err++; $display("FAIL midreset frac: got %0d want 0", $signed(bus.Frac_Out)); end
    n_vec++; if (bus.Div_Ratio !== 8'd0) begin n_err++; $display("FAIL midreset div: got %0d want 0", bus.Div_Ratio); end
    n_vec++; if (bus.Sat !== 1'b0) begin n_err++; $display("FAIL midreset sat: got %b want 0", bus.Sat); end
    n_vec++; if (bus.Valid !== 1'b0) begin n_err++; $display("FAIL midreset valid: got %b want 0", bus.Valid); end
    @(negedge Clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1'b0, 1'b1);
      n_vec++;
      if (bus.Valid !== (i == 2)) begin
        n_err++; $display("FAIL reprime valid[%0d]: got %b want %b", i, bus.Valid, (i == 2));
      end
    end
  endtask

  task automatic test_order3_step();
    int   exp_f[4] = '{1, -1, 0, 0};
    int   exp_d[4] = '{65, 63, 64, 64};
    logic exp_v[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    bus.Order = 2'd3;
    bus.N_Int = 8'd64;
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, 1'b0, 1'b1);
      n_vec++; if (bus.Frac_Out !== 4'(exp_f[i])) begin n_err++; $display("FAIL step frac[%0d]: got %0d want %0d", i, $signed(bus.Frac_Out), exp_f[i]); end
      n_vec++; if (bus.Div_Ratio !== 8'(exp_d[i])) begin n_err++; $display("FAIL step div[%0d]: got %0d want %0d", i, bus.Div_Ratio, exp_d[i]); end
      n_vec++; if (bus.Valid !== exp_v[i]) begin n_err++; $display("FAIL step valid[%0d]: got %b want %b", i, bus.Valid, exp_v[i]); end
    end
  endtask

  // Carry patterns that drive y to +4 on the third strobe and -3 on the fourth.
  task automatic test_extremes();
    logic [2:0] pat[4]   = '{3'b001, 3'b000, 3'b111, 3'b000};
    int         exp_f[4] = '{1, -2, 4, -3};
    int         exp_d[4] = '{101, 98, 104, 97};
    do_reset();
    bus.Order = 2'd3;
    bus.N_Int = 8'd100;
    for (int i = 0; i < 4; i++) begin
      strobe(pat[i][2], pat[i][1], pat[i][0]);
      n_vec++; if (bus.Frac_Out !== 4'(exp_f[i])) begin n_err++; $display("FAIL extreme frac[%0d]: got %0d want %0d", i, $signed(bus.Frac_Out), exp_f[i]); end
      n_vec++; if (bus.Div_Ratio !== 8'(exp_d[i])) begin n_err++; $display("FAIL extreme div[%0d]: got %0d want %0d", i, bus.Div_Ratio, exp_d[i]); end
      n_vec++; if (bus.Sat !== 1'b0) begin n_err++; $display("FAIL extreme sat[%0d]: got %b want 0", i, bus.Sat); end
    end
  endtask

  task automatic test_saturation();
    logic [2:0] pat[4]    = '{3'b001, 3'b000, 3'b111, 3'b000};
    int         n_int[2]  = '{1, 254};
    int         exp_d[2][4] = '{'{2, 0, 5, 0}, '{255, 252, 255, 251}};
    logic       exp_s[2][4] = '{'{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1, 1'b0}};
    for (int r = 0; r < 2; r++) begin
      do_reset();
      bus.Order = 2'd3;
      bus.N_Int = 8'(n_int[r]);
      for (int i = 0; i < 4; i++) begin
        strobe(pat[i][2], pat[i][1], pat[i][0]);
        n_vec++; if (bus.Div_Ratio !== 8'(exp_d[r][i])) begin n_err++; $display("FAIL sat div[N=%0d,%0d]: got %0d want %0d", n_int[r], i, bus.Div_Ratio, exp_d[r][i]); end
        n_vec++; if (bus.Sat !== exp_s[r][i]) begin n_err++; $display("FAIL sat flag[N=%0d,%0d]: got %b want %b", n_int[r], i, bus.Sat, exp_s[r][i]); end
      end
    end
  endtask

  task automatic test_en_gating();
    int exp_d[3] = '{65, 63, 64};
    do_reset();
    bus.Order = 2'd3;
    bus.N_Int = 8'd64;
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1'b0, 1'b1);
      n_vec++; if (bus.Div_Ratio !== 8'(exp_d[i])) begin n_err++; $display("FAIL gate pre div[%0d]: got %0d want %0d", i, bus.Div_Ratio, exp_d[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      bus.En = 1'b0;
      bus.C1 = ~bus.C1;
      bus.C2 = (i % 2 == 0);
      bus.C3 = (i == 4) ? 1'b0 : ~bus.C3;
      @(posedge Clk);
      #1;
      n_vec++; if (bus.Frac_Out !== 4'd0) begin n_err++; $display("FAIL gate hold frac[%0d]: got %0d want 0", i, $signed(bus.Frac_Out)); end
      n_vec++; if (bus.Div_Ratio !== 8'd64) begin n_err++; $display("FAIL gate hold div[%0d]: got %0d want 64", i, bus.Div_Ratio); end
    end
    strobe(1'b0, 1'b0, 1'b1);
    n_vec++; if (bus.Frac_Out !== 4'd0) begin n_err++; $display("FAIL gate resume frac: got %0d want 0", $signed(bus.Frac_Out)); end
    n_vec++; if (bus.Div_Ratio !== 8'd64) begin n_err++; $display("FAIL gate resume div: got %0d want 64", bus.Div_Ratio); end
  endtask

  // C2 is held high throughout so MASH-2 starts with c2_d1 already 1.
  task automatic test_order_switch();
    logic [1:0] ord[5]   = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2};
    logic       c1[5]    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int         exp_f[5] = '{1, 0, 0, 1, 0};
    int         exp_d[5] = '{51, 50, 50, 51, 50};
    do_reset();
    bus.N_Int = 8'd50;
    for (int i = 0; i < 5; i++) begin
      bus.Order = ord[i];
      strobe(c1[i], 1'b1, 1'b0);
      n_vec++; if (bus.Frac_Out !== 4'(exp_f[i])) begin n_err++; $display("FAIL switch frac[%0d]: got %0d want %0d", i, $signed(bus.Frac_Out), exp_f[i]); end
      n_vec++; if (bus.Div_Ratio !== 8'(exp_d[i])) begin n_err++; $display("FAIL switch div[%0d]: got %0d want %0d", i, bus.Div_Ratio, exp_d[i]); end
    end
  endtask

  initial begin
    bus.En    = 1'b0;
    bus.C1    = 1'b0;
    bus.C2    = 1'b0;
    bus.C3    = 1'b0;
    bus.Order = 2'd0;
    bus.N_Int = 8'd0;
    test_reset();
    test_order3_step();
    test_extremes();
    test_saturation();
    test_en_gating();
    test_order_switch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
